// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states
// and the bit positions used by the region decoder.
package dmem_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

    localparam int IO_SEL_LSB = 16;
    localparam int IO_CH_LSB  = 2;
    localparam int IO_CH_MSB  = 5;

    function automatic logic ctrl_reserved(input logic [2:0] c);
        return c > DM_BYTE_U;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Lane steering for sub-word accesses: merges store data into the old RAM
// word, extracts and extends load data, and flags misaligned addresses.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  ctrl_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] old_i,
    output logic [31:0] st_word_o,
    output logic [31:0] ld_val_o,
    output logic        misalign_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = old_i[{off_i, 3'b000} +: 8];
        half_v     = off_i[1] ? old_i[31:16] : old_i[15:0];
        st_word_o  = old_i;
        ld_val_o   = '0;
        misalign_o = 1'b0;
        case (ctrl_i)
            DM_WORD: begin
                st_word_o  = wdata_i;
                ld_val_o   = old_i;
                misalign_o = |off_i;
            end
            DM_HALF, DM_HALF_U: begin
                if (off_i[1]) st_word_o[31:16] = wdata_i[15:0];
                else          st_word_o[15:0]  = wdata_i[15:0];
                ld_val_o   = {{16{half_v[15] & (ctrl_i == DM_HALF)}}, half_v};
                misalign_o = off_i[0];
            end
            DM_BYTE, DM_BYTE_U: begin
                st_word_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
                ld_val_o = {{24{byte_v[7] & (ctrl_i == DM_BYTE)}}, byte_v};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word RAM plus memory-mapped I/O behind a
// request/ready handshake with programmable wait states and fault reporting.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          ADDR_W      = 7,
    parameter int          WAIT_STATES = 0,
    parameter int          N_IO        = 4,
    parameter logic [15:0] IO_BASE     = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req,
    input  logic                 we,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic [2:0]           dm_ctrl,
    output logic [31:0]          rdata,
    output logic                 ready,
    output logic                 err,
    input  logic [32*N_IO-1:0]   io_in,
    output logic [32*N_IO-1:0]   io_out,
    output dmem_state_t          dbg_state
);

    // Handshake: req is sampled only in IDLE, where the request fields are
    // latched; ready is a single-cycle pulse in DONE, with rdata/err valid
    // alongside it. No backpressure exists on the response side.
    dmem_state_t         state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [2:0]          ctrl_q, ctrl_d;
    logic                err_q, err_d;
    logic [32*N_IO-1:0]  io_q, io_d;

    logic [31:0]         mem [2**ADDR_W];
    logic [ADDR_W-1:0]   word_idx;
    logic [31:0]         st_word, ld_val, io_rd;
    logic [3:0]          io_ch;
    logic                misalign, is_io, is_ram, ch_ok, fault, commit, ram_we;

    assign word_idx = addr_q[ADDR_W+1:2];
    assign io_ch    = addr_q[IO_CH_MSB:IO_CH_LSB];
    assign is_io    = addr_q[31:IO_SEL_LSB] == IO_BASE;
    assign is_ram   = addr_q[31:ADDR_W+2] == '0;
    assign ch_ok    = {1'b0, io_ch} < 5'(N_IO);
    assign commit   = (state_q == ST_BUSY) && (cnt_q == 4'd0);

    // I/O decode wins if IO_BASE ever overlaps the RAM window.
    assign fault = ctrl_reserved(ctrl_q) || misalign ||
                   (is_io ? ((ctrl_q != DM_WORD) || !ch_ok) : !is_ram);
    assign ram_we = commit && we_q && !fault && !is_io;

    dmem_align u_align (
        .off_i      (addr_q[1:0]),
        .ctrl_i     (ctrl_q),
        .wdata_i    (wdata_q),
        .old_i      (mem[word_idx]),
        .st_word_o  (st_word),
        .ld_val_o   (ld_val),
        .misalign_o (misalign)
    );

    always_comb begin
        io_rd = '0;
        for (int k = 0; k < N_IO; k++) begin
            if (io_ch == 4'(k)) io_rd = io_in[k*32 +: 32];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ctrl_d  = ctrl_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        io_d    = io_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    ctrl_d  = dm_ctrl;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_DONE;
                    err_d   = fault;
                    rdata_d = '0;
                    if (!fault && !we_q) rdata_d = is_io ? io_rd : ld_val;
                    if (!fault && we_q && is_io) begin
                        for (int k = 0; k < N_IO; k++) begin
                            if (io_ch == 4'(k)) io_d[k*32 +: 32] = wdata_q;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ctrl_q  <= DM_WORD;
            rdata_q <= '0;
            err_q   <= 1'b0;
            io_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            io_q    <= io_d;
        end
    end

    // RAM is not reset; an aborted access never reaches the commit state.
    always_ff @(posedge clk) begin
        if (ram_we) mem[word_idx] <= st_word;
    end

    assign rdata     = rdata_q;
    assign err       = err_q;
    assign ready     = (state_q == ST_DONE);
    assign io_out    = io_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (0 and 3 wait states) driven serially
// and checked every cycle against a byte-level memory/I/O model.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic         clk = 1'b0;
    logic         rstn0 = 1'b0, rstn3 = 1'b0;
    logic         req0 = 1'b0, req3 = 1'b0;
    logic         we = 1'b0;
    logic [31:0]  addr = '0, wdata = '0;
    logic [2:0]   dm_ctrl = '0;
    logic [127:0] io_in = '0;
    logic [31:0]  rdata0, rdata3;
    logic         ready0, ready3, err0, err3;
    logic [127:0] io_out0, io_out3;
    dmem_state_t  dbg0, dbg3;

    int n_cmp = 0, n_fail = 0;

    // model state, index 0 = zero-wait instance, 1 = three-wait instance
    logic [7:0]   mem_b [2][512];
    logic [127:0] io_vis [2];
    bit           pending [2];
    int           cyc [2], lat [2], exp_ch [2];
    bit           exp_err [2], exp_chk_rd [2], exp_iow [2];
    logic [31:0]  exp_rd [2], exp_wd [2];

    logic [31:0]  got_rd;
    bit           got_err;
    logic [127:0] got_io;
    int           last_lat;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(7), .WAIT_STATES(0), .N_IO(4), .IO_BASE(16'hFFFF)) u_dut0 (
        .clk(clk), .rstn(rstn0), .req(req0), .we(we), .addr(addr), .wdata(wdata),
        .dm_ctrl(dm_ctrl), .rdata(rdata0), .ready(ready0), .err(err0),
        .io_in(io_in), .io_out(io_out0), .dbg_state(dbg0));

    dmem_ctrl #(.ADDR_W(7), .WAIT_STATES(3), .N_IO(4), .IO_BASE(16'hFFFF)) u_dut3 (
        .clk(clk), .rstn(rstn3), .req(req3), .we(we), .addr(addr), .wdata(wdata),
        .dm_ctrl(dm_ctrl), .rdata(rdata3), .ready(ready3), .err(err3),
        .io_in(io_in), .io_out(io_out3), .dbg_state(dbg3));

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference behaviour: little-endian byte memory, size-based alignment.
    task automatic model(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] c, output bit e, output logic [31:0] r,
                         output bit iw, output int ch);
        int size;
        logic [31:0] val, ones;
        size = (c == 3'd0) ? 4 : (c <= 3'd2) ? 2 : (c <= 3'd4) ? 1 : 0;
        e = 0; r = '0; iw = 0; ch = 0; ones = '1;
        if (size == 0) e = 1;
        else if (int'(a[1:0]) % size != 0) e = 1;
        else if (a[31:16] == 16'hFFFF) begin
            ch = int'(a[5:2]);
            if (size != 4 || ch >= 4) e = 1;
            else if (w) iw = 1;
            else r = io_in[ch*32 +: 32];
        end else if (a >= 32'd512) e = 1;
        else if (w) begin
            for (int i = 0; i < size; i++) mem_b[d][int'(a) + i] = wd[8*i +: 8];
        end else begin
            val = '0;
            for (int i = 0; i < size; i++) val[8*i +: 8] = mem_b[d][int'(a) + i];
            if (size < 4 && (c == 3'd1 || c == 3'd3) && val[8*size-1])
                val = val | (ones << (8*size));
            r = val;
        end
    endtask

    task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] c, input bit hold);
        bit e, iw, rdy;
        logic [31:0] r;
        int ch, n;
        @(negedge clk);
        we = w; addr = a; wdata = wd; dm_ctrl = c;
        model(d, w, a, wd, c, e, r, iw, ch);
        exp_err[d] = e; exp_rd[d] = r; exp_chk_rd[d] = !w || e;
        exp_iow[d] = iw; exp_ch[d] = ch; exp_wd[d] = wd;
        cyc[d] = 0; lat[d] = (d == 0 ? 0 : 3) + 2; pending[d] = 1;
        if (d == 0) req0 = 1'b1; else req3 = 1'b1;
        n = 0; rdy = 0;
        while (!rdy && n < 40) begin
            @(posedge clk); #1; n++;
            rdy = (d == 0) ? ready0 : ready3;
            if (rdy) begin
                got_rd  = (d == 0) ? rdata0 : rdata3;
                got_err = (d == 0) ? err0 : err3;
                got_io  = (d == 0) ? io_out0 : io_out3;
            end
            @(negedge clk);
            if (!hold || rdy) begin
                if (d == 0) req0 = 1'b0; else req3 = 1'b0;
            end
        end
        last_lat = n;
        if (!rdy) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout dut%0d: no ready after %0d edges, required within 40", d, n);
            pending[d] = 0;
        end
    endtask

    // Per-cycle compare of every instance against the model.
    always begin
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            bit rdy, exp_rdy;
            rdy = (d == 0) ? ready0 : ready3;
            exp_rdy = 0;
            if (pending[d]) begin
                cyc[d]++;
                exp_rdy = (cyc[d] == lat[d]);
            end
            chk($sformatf("dut%0d ready cyc%0d", d, cyc[d]), 128'(rdy), 128'(exp_rdy));
            if (pending[d] && exp_rdy) begin
                if (exp_iow[d]) io_vis[d][exp_ch[d]*32 +: 32] = exp_wd[d];
                chk($sformatf("dut%0d err", d), 128'(d == 0 ? err0 : err3), 128'(exp_err[d]));
                if (exp_chk_rd[d])
                    chk($sformatf("dut%0d rdata", d), 128'(d == 0 ? rdata0 : rdata3), 128'(exp_rd[d]));
                pending[d] = 0;
            end
            chk($sformatf("dut%0d io_out", d), (d == 0) ? io_out0 : io_out3, io_vis[d]);
        end
    end

    initial begin
        io_vis[0] = '0; io_vis[1] = '0;
        pending[0] = 0; pending[1] = 0;
        repeat (3) @(negedge clk);
        rstn0 = 1'b1; rstn3 = 1'b1;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 128; i++) access(d, 1, 32'(i * 4), $urandom, DM_WORD, 0);

        // directed word/byte/half traffic on the zero-wait instance
        access(0, 1, 32'h10, 32'hDEADBEEF, DM_WORD, 0);
        chk("lat ws0", 128'(last_lat), 128'd2);
        access(0, 0, 32'h10, 0, DM_WORD, 0);
        chk("ld word", 128'(got_rd), 128'hDEADBEEF);
        chk("ld word err", 128'(got_err), 128'd0);
        access(0, 1, 32'h11, 32'h5A, DM_BYTE, 0);
        access(0, 0, 32'h10, 0, DM_WORD, 0);
        chk("after sb", 128'(got_rd), 128'hDEAD5AEF);
        access(0, 0, 32'h13, 0, DM_BYTE, 0);
        chk("lb", 128'(got_rd), 128'hFFFFFFDE);
        access(0, 0, 32'h13, 0, DM_BYTE_U, 0);
        chk("lbu", 128'(got_rd), 128'h000000DE);
        access(0, 0, 32'h12, 0, DM_HALF, 0);
        chk("lh", 128'(got_rd), 128'hFFFFDEAD);

        access(0, 1, 32'h12, 32'h11111111, DM_WORD, 0);
        chk("sw misalign err", 128'(got_err), 128'd1);
        access(0, 1, 32'h11, 32'h2222, DM_HALF, 0);
        chk("sh misalign err", 128'(got_err), 128'd1);
        access(0, 0, 32'h400, 0, DM_WORD, 0);
        chk("oor err", 128'(got_err), 128'd1);
        chk("oor rdata", 128'(got_rd), 128'd0);
        access(0, 0, 32'h10, 0, 3'b101, 0);
        chk("rsvd err", 128'(got_err), 128'd1);
        chk("rsvd rdata", 128'(got_rd), 128'd0);
        access(0, 0, 32'h10, 0, DM_WORD, 0);
        chk("after faults", 128'(got_rd), 128'hDEAD5AEF);

        access(0, 1, 32'hFFFF0008, 32'h1234, DM_WORD, 0);
        chk("io ch2 done", 128'(got_io[95:64]), 128'h1234);
        io_in = {32'h0, 32'h0, 32'hA5A5, 32'h0};
        access(0, 0, 32'hFFFF0004, 0, DM_WORD, 0);
        chk("io ld ch1", 128'(got_rd), 128'hA5A5);
        access(0, 0, 32'hFFFF0010, 0, DM_WORD, 0);
        chk("io ch4 err", 128'(got_err), 128'd1);

        // wait states with req held through BUSY
        access(1, 1, 32'h40, 32'h0BADCAFE, DM_WORD, 1);
        chk("lat ws3 st", 128'(last_lat), 128'd5);
        access(1, 0, 32'h40, 0, DM_WORD, 1);
        chk("lat ws3 ld", 128'(last_lat), 128'd5);
        chk("ws3 rdata", 128'(got_rd), 128'h0BADCAFE);

        // reset during BUSY aborts the store
        access(0, 1, 32'h20, 32'h13579BDF, DM_WORD, 0);
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; dm_ctrl = DM_WORD; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0; rstn0 = 1'b0; io_vis[0] = '0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst ready", 128'(ready0), 128'd0);
            chk("rst err", 128'(err0), 128'd0);
            chk("rst io_out", io_out0, 128'd0);
        end
        @(negedge clk);
        rstn0 = 1'b1;
        access(0, 0, 32'h20, 0, DM_WORD, 0);
        chk("abort keeps mem", 128'(got_rd), 128'h13579BDF);

        // randomized traffic
        for (int t = 0; t < 300; t++) begin
            int d, kind;
            logic [31:0] a;
            logic [2:0] c;
            d = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            if (kind <= 6)      a = 32'($urandom_range(0, 511));
            else if (kind <= 8) a = 32'hFFFF0000 | 32'($urandom_range(0, 63));
            else                a = $urandom | 32'h1000;
            c = 3'($urandom_range(0, 5));
            if (c == 3'd5) c = 3'($urandom_range(5, 7));
            io_in = {$urandom, $urandom, $urandom, $urandom};
            access(d, 1'($urandom_range(0, 1)), a, $urandom, c, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
